iddr_align_ctrl: RTL and testbench

- Training/alignment sequencer for one DDR input capture cell: drives its polarity select (DDRCLKPOL), reset and clock-enable, and checks the captured QA/QB pair against a static training pattern.
- Sweeps four configurations {SWAP, DDRCLKPOL} until a run of consecutive good samples is seen, then reports lock and the lane-swap setting for downstream word assembly.
- Sits in the SCLK domain beside each IDDR instance in the input interface.

---
 rtl/iddr_align_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_iddr_align_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/iddr_align_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : iddr_align_ctrl
// Brief    : IDDR training sequencer; sweeps {SWAP,DDRCLKPOL} until lock.
// Revision : 1.0 - initial release
// ============================================================================
module iddr_align_ctrl #(
    parameter logic PAT_A      = 1'b1,
    parameter logic PAT_B      = 1'b0,
    parameter int   RST_CYC    = 2,
    parameter int   SETTLE_CYC = 4,
    parameter int   MATCH_CNT  = 16,
    parameter int   MAX_TRIES  = 3
) (
    input  logic SCLK,
    input  logic RSTN,
    input  logic START,
    input  logic QA,
    input  logic QB,
    output logic DDRCLKPOL,
    output logic IDDR_RST,
    output logic IDDR_CE,
    output logic SWAP,
    output logic BUSY,
    output logic LOCKED,
    output logic FAIL
);

    localparam int c_MAX_CYC = (RST_CYC > SETTLE_CYC)
                             ? ((RST_CYC > MATCH_CNT) ? RST_CYC : MATCH_CNT)
                             : ((SETTLE_CYC > MATCH_CNT) ? SETTLE_CYC : MATCH_CNT);
    localparam int c_CNT_W = $clog2(c_MAX_CYC) + 1;
    localparam int c_TRY_W = $clog2(MAX_TRIES + 1);

    localparam logic [c_CNT_W-1:0] c_RST_LAST   = c_CNT_W'(RST_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SET_LAST   = c_CNT_W'(SETTLE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_MATCH_LAST = c_CNT_W'(MATCH_CNT - 1);
    localparam logic [c_TRY_W-1:0] c_TRY_LAST   = c_TRY_W'(MAX_TRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_NEXT   = 3'd4,
        S_LOCK   = 3'd5,
        S_FAILED = 3'd6
    } state_t;

    state_t               r_state, w_state_nx;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [1:0]           r_cfg, w_cfg_nx;
    logic [c_TRY_W-1:0]   r_tries, w_tries_nx;
    logic                 r_iddr_rst, r_iddr_ce, r_busy, r_locked, r_fail;
    logic                 w_iddr_rst_nx, w_iddr_ce_nx, w_busy_nx, w_locked_nx, w_fail_nx;
    logic                 w_ea, w_eb, w_good;

    // cfg[1] is the lane swap: downstream sees QB as the first-in-time bit
    assign w_ea   = r_cfg[1] ? QB : QA;
    assign w_eb   = r_cfg[1] ? QA : QB;
    assign w_good = (w_ea === PAT_A) && (w_eb === PAT_B);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_cfg_nx   = r_cfg;
        w_tries_nx = r_tries;
        case (r_state)
            S_IDLE, S_LOCK, S_FAILED: begin
                if (START) begin
                    w_state_nx = S_RESET;
                    w_cnt_nx   = '0;
                    w_cfg_nx   = 2'd0;
                    w_tries_nx = '0;
                end
            end
            S_RESET: begin
                if (r_cnt == c_RST_LAST) begin
                    w_state_nx = S_SETTLE;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_cnt == c_SET_LAST) begin
                    w_state_nx = S_CHECK;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (!w_good) begin
                    w_state_nx = S_NEXT;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_MATCH_LAST) begin
                    w_state_nx = S_LOCK;
                    w_cnt_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_NEXT: begin
                w_state_nx = S_RESET;
                if (r_cfg != 2'd3) begin
                    w_cfg_nx = r_cfg + 2'd1;
                end else begin
                    w_cfg_nx   = 2'd0;
                    w_tries_nx = r_tries + 1'b1;
                    if (r_tries == c_TRY_LAST) begin
                        w_state_nx = S_FAILED;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they register with it
    always_comb begin
        w_iddr_rst_nx = 1'b1;
        w_iddr_ce_nx  = 1'b0;
        w_busy_nx     = 1'b0;
        w_locked_nx   = 1'b0;
        w_fail_nx     = 1'b0;
        case (w_state_nx)
            S_RESET, S_NEXT: begin
                w_busy_nx = 1'b1;
            end
            S_SETTLE, S_CHECK: begin
                w_iddr_rst_nx = 1'b0;
                w_iddr_ce_nx  = 1'b1;
                w_busy_nx     = 1'b1;
            end
            S_LOCK: begin
                w_iddr_rst_nx = 1'b0;
                w_iddr_ce_nx  = 1'b1;
                w_locked_nx   = 1'b1;
            end
            S_FAILED: begin
                w_fail_nx = 1'b1;
            end
            default: begin
                w_iddr_rst_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge SCLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cfg      <= 2'd0;
            r_tries    <= '0;
            r_iddr_rst <= 1'b1;
            r_iddr_ce  <= 1'b0;
            r_busy     <= 1'b0;
            r_locked   <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_cfg      <= w_cfg_nx;
            r_tries    <= w_tries_nx;
            r_iddr_rst <= w_iddr_rst_nx;
            r_iddr_ce  <= w_iddr_ce_nx;
            r_busy     <= w_busy_nx;
            r_locked   <= w_locked_nx;
            r_fail     <= w_fail_nx;
        end
    end

    assign DDRCLKPOL = r_cfg[0];
    assign SWAP      = r_cfg[1];
    assign IDDR_RST  = r_iddr_rst;
    assign IDDR_CE   = r_iddr_ce;
    assign BUSY      = r_busy;
    assign LOCKED    = r_locked;
    assign FAIL      = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_iddr_align_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_iddr_align_ctrl
// Brief    : Scoreboard bench for iddr_align_ctrl against a timeline model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iddr_align_ctrl;

    localparam int   RST_CYC    = 2;
    localparam int   SETTLE_CYC = 4;
    localparam int   MATCH_CNT  = 16;
    localparam int   MAX_TRIES  = 3;
    localparam int   TAIL       = 3;
    localparam logic PAT_A      = 1'b1;
    localparam logic PAT_B      = 1'b0;

    // {IDDR_RST, IDDR_CE, BUSY, LOCKED, FAIL, DDRCLKPOL, SWAP}
    typedef logic [6:0] obs_t;

    logic SCLK  = 1'b0;
    logic RSTN  = 1'b1;
    logic START = 1'b0;
    logic QA    = 1'b0;
    logic QB    = 1'b0;
    wire  DDRCLKPOL, IDDR_RST, IDDR_CE, SWAP, BUSY, LOCKED, FAIL;

    iddr_align_ctrl #(
        .PAT_A      (PAT_A),
        .PAT_B      (PAT_B),
        .RST_CYC    (RST_CYC),
        .SETTLE_CYC (SETTLE_CYC),
        .MATCH_CNT  (MATCH_CNT),
        .MAX_TRIES  (MAX_TRIES)
    ) dut (
        .SCLK      (SCLK),
        .RSTN      (RSTN),
        .START     (START),
        .QA        (QA),
        .QB        (QB),
        .DDRCLKPOL (DDRCLKPOL),
        .IDDR_RST  (IDDR_RST),
        .IDDR_CE   (IDDR_CE),
        .SWAP      (SWAP),
        .BUSY      (BUSY),
        .LOCKED    (LOCKED),
        .FAIL      (FAIL)
    );

    always #5 SCLK = ~SCLK;

    int    n_chk  = 0;
    int    n_pass = 0;
    string cur_tag = "init";

    obs_t  exp_q[$];
    int    idx_q[$];

    // Expected timeline: tl[e] = outputs after START-relative edge e;
    // drv_*[e] = raw IDDR outputs presented to edge e.
    obs_t  tl[0:511];
    logic  drv_a[0:511];
    logic  drv_b[0:511];
    bit    drv_x[0:511];
    int    tl_len;
    int    m_e;
    logic [1:0] m_pr0, m_pr1;

    function automatic obs_t mk(input logic r, input logic c, input logic b,
                                input logic l, input logic f, input logic p,
                                input logic s);
        return {r, c, b, l, f, p, s};
    endfunction

    function automatic obs_t actual();
        return {IDDR_RST, IDDR_CE, BUSY, LOCKED, FAIL, DDRCLKPOL, SWAP};
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: rst/ce/busy/lk/fl/pol/swp got %b required %b", name, act, exp);
    endtask

    task automatic push(input obs_t o, input int n);
        for (int i = 0; i < n; i++) begin
            tl[m_e] = o;
            {drv_a[m_e+1], drv_b[m_e+1]} = o[1] ? m_pr1 : m_pr0;
            drv_x[m_e+1] = 1'b0;
            m_e++;
        end
    endtask

    // Reference: walk configurations in order, each attempt costing reset,
    // settle, the samples taken and one NEXT cycle, until lock or exhaustion.
    task automatic build(input logic [1:0] pr0, input logic [1:0] pr1,
                         input int inj_e, input int inj_k);
        bit   locked;
        int   fc;
        logic pol, swp, ea, eb, good;
        int   s;
        m_pr0 = pr0;
        m_pr1 = pr1;
        m_e   = 0;
        {drv_a[0], drv_b[0]} = pr0;
        drv_x[0] = 1'b0;
        locked = 0;
        fc     = 0;
        for (int tr = 0; tr < MAX_TRIES && !locked; tr++) begin
            for (int c = 0; c < 4 && !locked; c++) begin
                pol = c[0];
                swp = c[1];
                push(mk(1, 0, 1, 0, 0, pol, swp), RST_CYC);
                push(mk(0, 1, 1, 0, 0, pol, swp), SETTLE_CYC);
                for (int k = 1; k <= MATCH_CNT; k++) begin
                    push(mk(0, 1, 1, 0, 0, pol, swp), 1);
                    s = m_e;
                    if (s == inj_e && inj_k == 1) drv_a[s] = ~drv_a[s];
                    if (s == inj_e && inj_k == 2) drv_x[s] = 1'b1;
                    ea   = swp ? drv_b[s] : drv_a[s];
                    eb   = swp ? drv_a[s] : drv_b[s];
                    good = !drv_x[s] && (ea == PAT_A) && (eb == PAT_B);
                    if (!good) begin
                        push(mk(1, 0, 1, 0, 0, pol, swp), 1);
                        break;
                    end
                    if (k == MATCH_CNT) begin
                        locked = 1;
                        fc     = c;
                    end
                end
            end
        end
        if (locked) push(mk(0, 1, 0, 1, 0, fc[0], fc[1]), TAIL);
        else        push(mk(1, 0, 0, 0, 1, 0, 0), TAIL);
        tl_len = m_e;
    endtask

    always @(negedge SCLK) begin : monitor
        obs_t ex;
        int   ix;
        if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            ix = idx_q.pop_front();
            check_obs($sformatf("%s_edge%0d", cur_tag, ix), actual(), ex);
        end
    end

    task automatic run(input logic [1:0] pr0, input logic [1:0] pr1, input int inj_e,
                       input int inj_k, input int busy_e, input string tag);
        int guard;
        build(pr0, pr1, inj_e, inj_k);
        @(negedge SCLK);
        #2;
        cur_tag = tag;
        START = 1'b1;
        QA = drv_a[0];
        QB = drv_b[0];
        for (int e = 0; e < tl_len; e++) begin
            exp_q.push_back(tl[e]);
            idx_q.push_back(e);
        end
        for (int e = 1; e < tl_len; e++) begin
            @(negedge SCLK);
            #2;
            START = (e == busy_e);
            QA = drv_x[e] ? 1'bx : drv_a[e];
            QB = drv_b[e];
        end
        START = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            @(negedge SCLK);
            #1;
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL %s_drain: %0d entries left, required 0", tag, exp_q.size());
            exp_q.delete();
            idx_q.delete();
        end
    endtask

    initial begin
        #3 RSTN = 1'b0;
        repeat (2) @(negedge SCLK);
        check_obs("reset_state", actual(), mk(1, 0, 0, 0, 0, 0, 0));
        #2 RSTN = 1'b1;
        @(negedge SCLK);
        check_obs("idle_state", actual(), mk(1, 0, 0, 0, 0, 0, 0));

        run(2'b10, 2'b10, 0, 0, 0, "lock_cfg0");
        run(2'b01, 2'b10, 0, 0, 0, "lock_cfg1");
        run(2'b01, 2'b01, 0, 0, 0, "lock_cfg2");
        run(2'b00, 2'b00, 0, 0, 0, "fail_all");
        run(2'b10, 2'b10, 0, 0, 0, "restart_after_fail");
        run(2'b10, 2'b10, 22, 1, 0, "bad_at_16th");
        run(2'b10, 2'b10, 9, 2, 12, "x_and_busy_start");

        for (int r = 0; r < 8; r++) begin
            run(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                int'($urandom_range(7, 150)), int'($urandom_range(0, 1)),
                int'($urandom_range(2, 20)), $sformatf("rand%0d", r));
        end

        // Asynchronous reset in the middle of CHECK
        QA = 1'b1;
        QB = 1'b0;
        @(negedge SCLK);
        #2 START = 1'b1;
        @(negedge SCLK);
        #2 START = 1'b0;
        repeat (10) @(posedge SCLK);
        #2;
        check_obs("pre_reset_check", actual(), mk(0, 1, 1, 0, 0, 0, 0));
        #1 RSTN = 1'b0;
        #1;
        check_obs("async_reset", actual(), mk(1, 0, 0, 0, 0, 0, 0));
        @(negedge SCLK);
        check_obs("reset_held", actual(), mk(1, 0, 0, 0, 0, 0, 0));
        #2 RSTN = 1'b1;
        @(negedge SCLK);
        check_obs("idle_after_reset", actual(), mk(1, 0, 0, 0, 0, 0, 0));

        run(2'b01, 2'b10, 0, 0, 0, "post_reset_lock");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
